// File: rtl/ad9643_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// ad9643_cfg_sequencer
//   AXI-Lite master that writes the AD9643 capture-core init table after reset.
//   Rev 1.0 - initial release
// ============================================================================
module ad9643_cfg_sequencer #(
    parameter logic [31:0] MODE_INIT   = 32'h0,
    parameter logic [31:0] CTRL_RUN    = 32'h2,
    parameter int          RESET_HOLD  = 16,
    parameter int          TIMEOUT_CYC = 255,
    parameter bit          VERIFY_EN   = 1'b1,
    parameter bit          AUTO_START  = 1'b1
) (
    input  logic        s_axi_aclk,
    input  logic        s_axi_areset,
    input  logic        start,
    output logic [31:0] m_axi_awaddr,
    output logic [2:0]  m_axi_awprot,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [31:0] m_axi_araddr,
    output logic [2:0]  m_axi_arprot,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [1:0]  err_index
);

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_AW   = 4'd1,
        ST_W    = 4'd2,
        ST_B    = 4'd3,
        ST_AR   = 4'd4,
        ST_R    = 4'd5,
        ST_HOLD = 4'd6,
        ST_NEXT = 4'd7,
        ST_DONE = 4'd8,
        ST_ERR  = 4'd9
    } state_t;

    localparam logic [7:0]  TMO_LAST   = 8'(TIMEOUT_CYC - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(RESET_HOLD - 1);
    localparam logic [1:0]  ERR_TMO    = 2'd1;
    localparam logic [1:0]  ERR_RESP   = 2'd2;
    localparam logic [1:0]  ERR_VERIFY = 2'd3;
    localparam logic [1:0]  LAST_IDX   = 2'd2;

    function automatic logic [31:0] tbl_addr(input logic [1:0] i);
        return (i == 2'd1) ? 32'h1 : 32'h0;
    endfunction

    function automatic logic [31:0] tbl_data(input logic [1:0] i);
        case (i)
            2'd0:    return 32'h1;
            2'd1:    return MODE_INIT;
            default: return CTRL_RUN;
        endcase
    endfunction

    state_t      state_q;
    logic [1:0]  idx_q;
    logic [7:0]  tmo_q;
    logic [15:0] hold_q;
    logic        first_q;
    logic [31:0] awaddr_q;
    logic [31:0] wdata_q;
    logic [31:0] araddr_q;
    logic        awvalid_q;
    logic        wvalid_q;
    logic        bready_q;
    logic        arvalid_q;
    logic        rready_q;
    logic        busy_q;
    logic        done_q;
    logic        error_q;
    logic [1:0]  err_code_q;
    logic [1:0]  err_index_q;

    logic        launch_d;
    logic        tmo_hit_d;
    logic        abort_d;
    logic [1:0]  abort_code_d;
    logic [1:0]  idx_nx_d;

    // The first cycle after reset release belongs to AUTO_START; a start pulse there is dropped.
    assign launch_d  = first_q ? AUTO_START : start;
    assign tmo_hit_d = (tmo_q == TMO_LAST);
    assign idx_nx_d  = idx_q + 2'd1;

    always_comb begin
        abort_d      = 1'b0;
        abort_code_d = 2'd0;
        case (state_q)
            ST_AW: if (!m_axi_awready && tmo_hit_d) begin
                abort_d      = 1'b1;
                abort_code_d = ERR_TMO;
            end
            ST_W: if (!m_axi_wready && tmo_hit_d) begin
                abort_d      = 1'b1;
                abort_code_d = ERR_TMO;
            end
            ST_B: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != 2'b00) begin
                        abort_d      = 1'b1;
                        abort_code_d = ERR_RESP;
                    end
                end else if (tmo_hit_d) begin
                    abort_d      = 1'b1;
                    abort_code_d = ERR_TMO;
                end
            end
            ST_AR: if (!m_axi_arready && tmo_hit_d) begin
                abort_d      = 1'b1;
                abort_code_d = ERR_TMO;
            end
            ST_R: begin
                if (m_axi_rvalid) begin
                    if (m_axi_rresp != 2'b00) begin
                        abort_d      = 1'b1;
                        abort_code_d = ERR_RESP;
                    end else if (m_axi_rdata != tbl_data(idx_q)) begin
                        abort_d      = 1'b1;
                        abort_code_d = ERR_VERIFY;
                    end
                end else if (tmo_hit_d) begin
                    abort_d      = 1'b1;
                    abort_code_d = ERR_TMO;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            tmo_q       <= 8'd0;
            hold_q      <= 16'd0;
            first_q     <= 1'b1;
            awaddr_q    <= 32'h0;
            wdata_q     <= 32'h0;
            araddr_q    <= 32'h0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= 2'd0;
            err_index_q <= 2'd0;
        end else begin
            first_q <= 1'b0;
            if (abort_d) begin
                // Dropping every valid/ready mid-burst is a deliberate abort of the slave transaction.
                state_q     <= ST_ERR;
                awvalid_q   <= 1'b0;
                wvalid_q    <= 1'b0;
                bready_q    <= 1'b0;
                arvalid_q   <= 1'b0;
                rready_q    <= 1'b0;
                busy_q      <= 1'b0;
                error_q     <= 1'b1;
                err_code_q  <= abort_code_d;
                err_index_q <= idx_q;
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE, ST_ERR: begin
                        if (launch_d) begin
                            state_q     <= ST_AW;
                            idx_q       <= 2'd0;
                            awaddr_q    <= tbl_addr(2'd0);
                            wdata_q     <= tbl_data(2'd0);
                            awvalid_q   <= 1'b1;
                            tmo_q       <= 8'd0;
                            busy_q      <= 1'b1;
                            done_q      <= 1'b0;
                            error_q     <= 1'b0;
                            err_code_q  <= 2'd0;
                            err_index_q <= 2'd0;
                        end
                    end
                    ST_AW: begin
                        if (m_axi_awready) begin
                            awvalid_q <= 1'b0;
                            wvalid_q  <= 1'b1;
                            tmo_q     <= 8'd0;
                            state_q   <= ST_W;
                        end else begin
                            tmo_q <= tmo_q + 8'd1;
                        end
                    end
                    ST_W: begin
                        if (m_axi_wready) begin
                            wvalid_q <= 1'b0;
                            bready_q <= 1'b1;
                            tmo_q    <= 8'd0;
                            state_q  <= ST_B;
                        end else begin
                            tmo_q <= tmo_q + 8'd1;
                        end
                    end
                    ST_B: begin
                        if (m_axi_bvalid) begin
                            bready_q <= 1'b0;
                            tmo_q    <= 8'd0;
                            hold_q   <= 16'd0;
                            if (VERIFY_EN) begin
                                arvalid_q <= 1'b1;
                                araddr_q  <= tbl_addr(idx_q);
                                state_q   <= ST_AR;
                            end else begin
                                state_q <= (idx_q == 2'd0) ? ST_HOLD : ST_NEXT;
                            end
                        end else begin
                            tmo_q <= tmo_q + 8'd1;
                        end
                    end
                    ST_AR: begin
                        if (m_axi_arready) begin
                            arvalid_q <= 1'b0;
                            rready_q  <= 1'b1;
                            tmo_q     <= 8'd0;
                            state_q   <= ST_R;
                        end else begin
                            tmo_q <= tmo_q + 8'd1;
                        end
                    end
                    ST_R: begin
                        if (m_axi_rvalid) begin
                            rready_q <= 1'b0;
                            hold_q   <= 16'd0;
                            state_q  <= (idx_q == 2'd0) ? ST_HOLD : ST_NEXT;
                        end else begin
                            tmo_q <= tmo_q + 8'd1;
                        end
                    end
                    ST_HOLD: begin
                        // Core soft reset (ctrl_reg=1) must settle before mode_reg is touched.
                        if (hold_q == HOLD_LAST) begin
                            state_q <= ST_NEXT;
                        end else begin
                            hold_q <= hold_q + 16'd1;
                        end
                    end
                    ST_NEXT: begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            idx_q     <= idx_nx_d;
                            awaddr_q  <= tbl_addr(idx_nx_d);
                            wdata_q   <= tbl_data(idx_nx_d);
                            awvalid_q <= 1'b1;
                            tmo_q     <= 8'd0;
                            state_q   <= ST_AW;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign err_code      = err_code_q;
    assign err_index     = err_index_q;

endmodule
`default_nettype wire

// File: tb/tb_ad9643_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// tb_ad9643_cfg_sequencer
//   Directed bench with an AXI-Lite slave model and write/read scoreboard.
//   Rev 1.0 - initial release
// ============================================================================
module tb_ad9643_cfg_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic        busy, done, error;
    logic [1:0]  err_code, err_index;

    always #5 clk = ~clk;

    ad9643_cfg_sequencer dut (
        .s_axi_aclk    (clk),
        .s_axi_areset  (rst),
        .start         (start),
        .m_axi_awaddr  (awaddr),
        .m_axi_awprot  (awprot),
        .m_axi_awvalid (awvalid),
        .m_axi_awready (awready),
        .m_axi_wdata   (wdata),
        .m_axi_wstrb   (wstrb),
        .m_axi_wvalid  (wvalid),
        .m_axi_wready  (wready),
        .m_axi_bresp   (bresp),
        .m_axi_bvalid  (bvalid),
        .m_axi_bready  (bready),
        .m_axi_araddr  (araddr),
        .m_axi_arprot  (arprot),
        .m_axi_arvalid (arvalid),
        .m_axi_arready (arready),
        .m_axi_rdata   (rdata),
        .m_axi_rresp   (rresp),
        .m_axi_rvalid  (rvalid),
        .m_axi_rready  (rready),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .err_code      (err_code),
        .err_index     (err_index)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;
    int cyc = 0;

    wr_t         exp_wr[$];
    logic [31:0] exp_rd[$];
    wr_t         e_wr;
    logic [31:0] e_rd;
    logic [31:0] tbl_a[3] = '{32'h0, 32'h1, 32'h0};
    logic [31:0] tbl_d[3] = '{32'h1, 32'h0, 32'h2};

    // slave behaviour knobs (-1 = off)
    int aw_stall = 0;
    int b_block_idx = -1;
    int bresp_err_idx = -1;
    int corrupt_rd_idx = -1;

    int aw_n, w_n, b_n, rd_n, bstall, b0_cyc, aw1_cyc, aw_cnt;
    logic [31:0] mem[2];
    logic [31:0] cap_addr;
    logic        b_pend = 1'b0, r_pend = 1'b0;
    logic [1:0]  b_resp_v = 2'b00;
    logic [31:0] r_data_v = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Handshake monitor and scoreboard
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            b_pend = 1'b0;
            r_pend = 1'b0;
        end else begin
            if (bready && !bvalid) bstall++;
            if (awvalid && awready) begin
                cap_addr = awaddr;
                if (aw_n == 1) aw1_cyc = cyc;
                aw_n++;
            end
            if (wvalid && wready) begin
                if (exp_wr.size() == 0) begin
                    chk("wr_unexpected", 32'(exp_wr.size()), 32'd1);
                end else begin
                    e_wr = exp_wr.pop_front();
                    chk("wr_addr", cap_addr, e_wr.a);
                    chk("wr_data", wdata, e_wr.d);
                end
                mem[cap_addr[0]] = wdata;
                if (w_n != b_block_idx) begin
                    b_pend   = 1'b1;
                    b_resp_v = (w_n == bresp_err_idx) ? 2'b10 : 2'b00;
                end
                w_n++;
            end
            if (bvalid && bready) begin
                b_pend = 1'b0;
                if (b_n == 0) b0_cyc = cyc;
                b_n++;
            end
            if (arvalid && arready) begin
                if (exp_rd.size() == 0) begin
                    chk("rd_unexpected", 32'(exp_rd.size()), 32'd1);
                end else begin
                    e_rd = exp_rd.pop_front();
                    chk("rd_addr", araddr, e_rd);
                end
                r_pend   = 1'b1;
                r_data_v = (rd_n == corrupt_rd_idx) ? 32'h5 : mem[araddr[0]];
                rd_n++;
            end
            if (rvalid && rready) r_pend = 1'b0;
        end
    end

    // Slave drives its outputs on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
            arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
            aw_cnt  = 0;
        end else begin
            if (awvalid) begin
                awready = (aw_cnt >= aw_stall);
                aw_cnt++;
            end else begin
                awready = 1'b0;
                aw_cnt  = 0;
            end
            wready  = wvalid;
            arready = arvalid;
            bvalid  = b_pend;
            bresp   = b_resp_v;
            rvalid  = r_pend;
            rdata   = r_data_v;
            rresp   = 2'b00;
        end
    end

    task automatic arm(input int nw, input int nr);
        exp_wr.delete();
        exp_rd.delete();
        for (int i = 0; i < nw; i++) exp_wr.push_back({tbl_a[i], tbl_d[i]});
        for (int i = 0; i < nr; i++) exp_rd.push_back(tbl_a[i]);
        aw_n = 0; w_n = 0; b_n = 0; rd_n = 0; bstall = 0;
        b0_cyc = 0; aw1_cyc = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_end(input int bound);
        int n = 0;
        while (!(done || error) && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        chk("end_reached", 32'(done | error), 32'd1);
    endtask

    task automatic chk_queues();
        chk("wr_left", 32'(exp_wr.size()), 32'd0);
        chk("rd_left", 32'(exp_rd.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_flags", {awvalid, wvalid, bready, arvalid, rready, busy, done, error}, 32'd0);
        chk("rst_err", {err_code, err_index}, 32'd0);
        chk("rst_addr", awaddr | wdata | araddr, 32'd0);
        chk("fixed_sig", {awprot, arprot, wstrb}, 32'h00F);

        // Auto start, full verified pass
        arm(3, 3);
        @(negedge clk) rst = 1'b0;
        wait_end(1000);
        chk("auto_done", {done, error, busy}, 32'b100);
        chk("auto_rd_cnt", 32'(rd_n), 32'd3);
        chk("hold_gap", 32'((aw1_cyc - b0_cyc) >= 16), 32'd1);
        chk_queues();

        // awready held low 3 cycles; a start while busy must be ignored
        aw_stall = 3;
        arm(3, 3);
        pulse_start();
        for (int n = 0; n < 10 && !awvalid; n++) begin
            @(posedge clk); #1;
        end
        for (int k = 0; k < 4; k++) begin
            chk("stall_aw", {awvalid, wvalid, awaddr[3:0]}, 32'b10_0000);
            @(posedge clk); #1;
        end
        chk("stall_w_after", {awvalid, wvalid}, 32'b01);
        pulse_start();
        wait_end(1000);
        chk("stall_done", {done, error, busy}, 32'b100);
        chk_queues();
        aw_stall = 0;

        // No write response on entry 1 -> timeout
        b_block_idx = 1;
        arm(2, 1);
        pulse_start();
        wait_end(1000);
        chk("tmo_err", {error, done, busy, err_code, err_index}, {3'b100, 2'd1, 2'd1});
        chk("tmo_cycles", 32'(bstall), 32'd255);
        chk("tmo_valids", {awvalid, wvalid, bready, arvalid, rready}, 32'd0);
        chk_queues();
        b_block_idx = -1;

        // Readback mismatch on entry 1, then a clean rerun
        corrupt_rd_idx = 1;
        arm(2, 2);
        pulse_start();
        wait_end(1000);
        chk("cmp_err", {error, busy, err_code, err_index}, {2'b10, 2'd3, 2'd1});
        chk_queues();
        corrupt_rd_idx = -1;
        arm(3, 3);
        pulse_start();
        #1;
        chk("restart_clear", {busy, done, error}, 32'b100);
        wait_end(1000);
        chk("rerun_done", {done, error, busy}, 32'b100);
        chk_queues();

        // SLVERR on entry 2 write response
        bresp_err_idx = 2;
        arm(3, 2);
        pulse_start();
        wait_end(1000);
        chk("resp_err", {error, done, busy, err_code, err_index}, {3'b100, 2'd2, 2'd2});
        chk_queues();
        bresp_err_idx = -1;

        // Reset asserted during W phase, AUTO_START reruns from entry 0
        arm(3, 3);
        pulse_start();
        for (int n = 0; n < 20 && !wvalid; n++) begin
            @(posedge clk); #1;
        end
        chk("reach_w", 32'(wvalid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_flags", {awvalid, wvalid, bready, arvalid, rready, busy, done, error}, 32'd0);
        chk("midrst_addr", awaddr | wdata | araddr, 32'd0);
        arm(3, 3);
        @(negedge clk) rst = 1'b0;
        wait_end(1000);
        chk("midrst_done", {done, error, busy}, 32'b100);
        chk("midrst_wr_cnt", 32'(w_n), 32'd3);
        chk_queues();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
